// File: rtl/intersection_phase_scheduler_if.sv
// Board-side signal bundle for the intersection phase scheduler: sensors in,
// lamps/countdown/phase out. Signal names match the existing board top level.
interface intersection_phase_scheduler_if;
  logic [1:0] SW;
  logic       PED;
  logic [2:0] LED_N;
  logic [2:0] LED_E;
  logic       WALK;
  logic [5:0] SEC_LEFT;
  logic [2:0] PHASE;

  // The scheduler drives lamps and status; the board/bench drives sensors.
  modport master (
    input  SW,
    input  PED,
    output LED_N,
    output LED_E,
    output WALK,
    output SEC_LEFT,
    output PHASE
  );

  modport slave (
    output SW,
    output PED,
    input  LED_N,
    input  LED_E,
    input  WALK,
    input  SEC_LEFT,
    input  PHASE
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection phase scheduler with latched pedestrian request.
// Sequences green/yellow/all-red/walk phases against a one-second tick.
module intersection_phase_scheduler #(
  parameter int unsigned CNT_MAX     = 50000000,
  parameter int unsigned T_MIN_GREEN = 10,
  parameter int unsigned T_MAX_GREEN = 30,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_WALK      = 8
) (
  input  logic                           CLOCK_50,
  input  logic                           KEY,
  intersection_phase_scheduler_if.master io
);

  localparam int PW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CNT_MAX - 1);
  localparam logic [6:0]    T_MING_W   = 7'(T_MIN_GREEN);
  localparam logic [6:0]    T_MAXG_W   = 7'(T_MAX_GREEN);
  localparam logic [6:0]    T_YEL_W    = 7'(T_YELLOW);
  localparam logic [6:0]    T_AR_W     = 7'(T_ALLRED);
  localparam logic [6:0]    T_WALK_W   = 7'(T_WALK);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam logic DIR_N = 1'b0;
  localparam logic DIR_E = 1'b1;

  typedef enum logic [2:0] {
    N_GREEN  = 3'd0,
    N_YELLOW = 3'd1,
    ALLRED_N = 3'd2,
    E_GREEN  = 3'd3,
    E_YELLOW = 3'd4,
    ALLRED_E = 3'd5,
    PED_WALK = 3'd6
  } state_e;

  // Input synchronisers
  logic [1:0] sw_meta_q, sw_sync_q;
  logic       ped_meta_q, ped_sync_q, ped_prev_q;

  // Scheduler state
  state_e     state_q, state_d;
  logic       next_dir_q, next_dir_d;
  logic       ped_q, ped_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0] elapsed_q, elapsed_d;

  // Registered outputs
  logic [2:0] led_n_q, led_n_d;
  logic [2:0] led_e_q, led_e_d;
  logic       walk_q, walk_d;
  logic [5:0] sec_left_q, sec_left_d;
  logic [2:0] phase_q, phase_d;

  logic       north_car, east_car, ped_rise;
  logic       tick, entering;
  logic [6:0] el_next;

  // Remaining seconds of a phase of length dur after el whole seconds, floored at 0.
  function automatic logic [5:0] secs_left(input logic [6:0] dur, input logic [5:0] el);
    if ({1'b0, el} >= dur) return 6'd0;
    return 6'(dur - {1'b0, el});
  endfunction

  // NOTE: every clocked block uses non-blocking (<=) so all flops sample
  // pre-edge values; blocking here would let a flop see its neighbour's new value.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      sw_meta_q  <= 2'b00;
      sw_sync_q  <= 2'b00;
      ped_meta_q <= 1'b0;
      ped_sync_q <= 1'b0;
      ped_prev_q <= 1'b0;
    end else begin
      sw_meta_q  <= io.SW;
      sw_sync_q  <= sw_meta_q;
      ped_meta_q <= io.PED;
      ped_sync_q <= ped_meta_q;
      ped_prev_q <= ped_sync_q;
    end
  end

  assign north_car = sw_sync_q[0];
  assign east_car  = sw_sync_q[1];
  assign ped_rise  = ped_sync_q & ~ped_prev_q;

  assign tick    = (presc_q == PRESC_LAST);
  assign el_next = {1'b0, elapsed_q} + 7'd1;

  // NOTE: every variable written below gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    case (state_q)
      N_GREEN: begin
        if (tick && (east_car || ped_q) &&
            ((el_next >= T_MAXG_W) || ((el_next >= T_MING_W) && !north_car)))
          state_d = N_YELLOW;
      end
      N_YELLOW: begin
        if (tick && (el_next >= T_YEL_W)) state_d = ALLRED_N;
      end
      ALLRED_N: begin
        if (tick && (el_next >= T_AR_W)) begin
          if (ped_q) begin
            state_d    = PED_WALK;
            next_dir_d = DIR_E;
          end else begin
            state_d = E_GREEN;
          end
        end
      end
      E_GREEN: begin
        if (tick && (north_car || ped_q) &&
            ((el_next >= T_MAXG_W) || ((el_next >= T_MING_W) && !east_car)))
          state_d = E_YELLOW;
      end
      E_YELLOW: begin
        if (tick && (el_next >= T_YEL_W)) state_d = ALLRED_E;
      end
      ALLRED_E: begin
        if (tick && (el_next >= T_AR_W)) begin
          if (ped_q) begin
            state_d    = PED_WALK;
            next_dir_d = DIR_N;
          end else begin
            state_d = N_GREEN;
          end
        end
      end
      PED_WALK: begin
        if (tick && (el_next >= T_WALK_W))
          state_d = (next_dir_q == DIR_E) ? E_GREEN : N_GREEN;
      end
      default: state_d = N_GREEN;  // illegal code recovers without waiting for a tick
    endcase
  end

  assign entering = (state_d != state_q);

  always_comb begin
    presc_d = (entering || tick) ? '0 : presc_q + 1'b1;

    elapsed_d = elapsed_q;
    if (entering)
      elapsed_d = 6'd0;
    else if (tick && (elapsed_q != 6'd63))
      elapsed_d = elapsed_q + 6'd1;

    // Clearing on walk entry wins over a same-cycle press: that walk serves it.
    ped_d = ped_q;
    if (entering && (state_d == PED_WALK))
      ped_d = 1'b0;
    else if (ped_rise && (state_q != PED_WALK))
      ped_d = 1'b1;
  end

  // Outputs are decoded from next-state values so they update with the state.
  always_comb begin
    led_n_d    = LAMP_R;
    led_e_d    = LAMP_R;
    walk_d     = 1'b0;
    sec_left_d = 6'd0;
    phase_d    = state_d;
    case (state_d)
      N_GREEN: begin
        led_n_d    = LAMP_G;
        sec_left_d = secs_left(T_MAXG_W, elapsed_d);
      end
      N_YELLOW: begin
        led_n_d    = LAMP_Y;
        sec_left_d = secs_left(T_YEL_W, elapsed_d);
      end
      ALLRED_N, ALLRED_E: begin
        sec_left_d = secs_left(T_AR_W, elapsed_d);
      end
      E_GREEN: begin
        led_e_d    = LAMP_G;
        sec_left_d = secs_left(T_MAXG_W, elapsed_d);
      end
      E_YELLOW: begin
        led_e_d    = LAMP_Y;
        sec_left_d = secs_left(T_YEL_W, elapsed_d);
      end
      PED_WALK: begin
        walk_d     = 1'b1;
        sec_left_d = secs_left(T_WALK_W, elapsed_d);
      end
      default: begin
        led_n_d    = LAMP_G;
        sec_left_d = T_MAXG_W[5:0];
        phase_d    = N_GREEN;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_q    <= N_GREEN;
      next_dir_q <= DIR_E;
      ped_q      <= 1'b0;
      presc_q    <= '0;
      elapsed_q  <= 6'd0;
      led_n_q    <= LAMP_G;
      led_e_q    <= LAMP_R;
      walk_q     <= 1'b0;
      sec_left_q <= T_MAXG_W[5:0];
      phase_q    <= N_GREEN;
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      ped_q      <= ped_d;
      presc_q    <= presc_d;
      elapsed_q  <= elapsed_d;
      led_n_q    <= led_n_d;
      led_e_q    <= led_e_d;
      walk_q     <= walk_d;
      sec_left_q <= sec_left_d;
      phase_q    <= phase_d;
    end
  end

  assign io.LED_N    = led_n_q;
  assign io.LED_E    = led_e_q;
  assign io.WALK     = walk_q;
  assign io.SEC_LEFT = sec_left_q;
  assign io.PHASE    = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with a one-second tick of 5 clocks.
// Timeline tables are counted in clock edges since reset release.
module tb_intersection_phase_scheduler;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  typedef struct {
    bit         do_rst;
    logic [1:0] sw;
    logic       ped;
    int         n;
    logic [2:0] phase;
    logic [2:0] led_n;
    logic [2:0] led_e;
    logic       walk;
    logic [5:0] sec;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic key = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler #(
    .CNT_MAX(5)
  ) u_dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .io      (bus)
  );

  always #10 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [2:0] phase, input logic [2:0] ln,
                               input logic [2:0] le, input logic wk, input logic [5:0] sec);
    check({name, ".phase"}, 32'(bus.PHASE), 32'(phase));
    check({name, ".led_n"}, 32'(bus.LED_N), 32'(ln));
    check({name, ".led_e"}, 32'(bus.LED_E), 32'(le));
    check({name, ".walk"},  32'(bus.WALK),  32'(wk));
    check({name, ".sec"},   32'(bus.SEC_LEFT), 32'(sec));
  endtask

  // Assumes the caller sits at a falling edge; leaves KEY released at a falling edge.
  task automatic do_reset(input logic [1:0] sw, input logic ped);
    key = 1'b0;
    repeat (2) @(negedge clk);
    bus.SW  = sw;
    bus.PED = ped;
    key = 1'b1;
  endtask

  task automatic add(input bit r, input logic [1:0] sw, input logic ped, input int n,
                     input logic [2:0] ph, input logic [2:0] ln, input logic [2:0] le,
                     input logic wk, input logic [5:0] sec, input string name);
    vec_t v;
    v.do_rst = r; v.sw = sw; v.ped = ped; v.n = n; v.phase = ph;
    v.led_n = ln; v.led_e = le; v.walk = wk; v.sec = sec; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    bus.SW  = 2'b00;
    bus.PED = 1'b0;

    // Idle: no demand, North rests green, countdown saturates and holds 0.
    add(1, 2'b00, 0,   0, 3'd0, G, R, 0, 6'd30, "idle_reset");
    add(0, 2'b00, 0,   5, 3'd0, G, R, 0, 6'd29, "idle_k5");
    add(0, 2'b00, 0, 144, 3'd0, G, R, 0, 6'd1,  "idle_k149");
    add(0, 2'b00, 0,   1, 3'd0, G, R, 0, 6'd0,  "idle_k150");
    add(0, 2'b00, 0, 850, 3'd0, G, R, 0, 6'd0,  "idle_k1000");
    // East demand only: minimum green, yellow countdown, all-red, East rests.
    add(1, 2'b10, 0,   0, 3'd0, G, R, 0, 6'd30, "east_reset");
    add(0, 2'b10, 0,  49, 3'd0, G, R, 0, 6'd21, "east_k49");
    add(0, 2'b10, 0,   1, 3'd1, Y, R, 0, 6'd3,  "east_yel_k50");
    add(0, 2'b10, 0,   4, 3'd1, Y, R, 0, 6'd3,  "east_yel_k54");
    add(0, 2'b10, 0,   1, 3'd1, Y, R, 0, 6'd2,  "east_yel_k55");
    add(0, 2'b10, 0,   5, 3'd1, Y, R, 0, 6'd1,  "east_yel_k60");
    add(0, 2'b10, 0,   4, 3'd1, Y, R, 0, 6'd1,  "east_yel_k64");
    add(0, 2'b10, 0,   1, 3'd2, R, R, 0, 6'd1,  "east_ar_k65");
    add(0, 2'b10, 0,   4, 3'd2, R, R, 0, 6'd1,  "east_ar_k69");
    add(0, 2'b10, 0,   1, 3'd3, R, G, 0, 6'd30, "east_grn_k70");
    add(0, 2'b10, 0, 150, 3'd3, R, G, 0, 6'd0,  "east_rest_k220");
    // Both sides busy: maximum green each way, full cycle.
    add(1, 2'b11, 0, 149, 3'd0, G, R, 0, 6'd1,  "both_k149");
    add(0, 2'b11, 0,   1, 3'd1, Y, R, 0, 6'd3,  "both_k150");
    add(0, 2'b11, 0,  15, 3'd2, R, R, 0, 6'd1,  "both_k165");
    add(0, 2'b11, 0,   5, 3'd3, R, G, 0, 6'd30, "both_k170");
    add(0, 2'b11, 0, 149, 3'd3, R, G, 0, 6'd1,  "both_k319");
    add(0, 2'b11, 0,   1, 3'd4, R, Y, 0, 6'd3,  "both_k320");
    add(0, 2'b11, 0,  15, 3'd5, R, R, 0, 6'd1,  "both_k335");
    add(0, 2'b11, 0,   5, 3'd0, G, R, 0, 6'd30, "both_k340");
    add(0, 2'b11, 0, 150, 3'd1, Y, R, 0, 6'd3,  "both_k490");
    // Pedestrian: press in N_GREEN is served, press during walk is dropped.
    add(1, 2'b00, 1,   2, 3'd0, G, R, 0, 6'd30, "ped_k2");
    add(0, 2'b00, 0,  47, 3'd0, G, R, 0, 6'd21, "ped_k49");
    add(0, 2'b00, 0,   1, 3'd1, Y, R, 0, 6'd3,  "ped_k50");
    add(0, 2'b00, 0,  15, 3'd2, R, R, 0, 6'd1,  "ped_k65");
    add(0, 2'b00, 0,   5, 3'd6, R, R, 1, 6'd8,  "ped_walk_k70");
    add(0, 2'b00, 0,  10, 3'd6, R, R, 1, 6'd6,  "ped_walk_k80");
    add(0, 2'b00, 1,   2, 3'd6, R, R, 1, 6'd6,  "ped_walk_k82");
    add(0, 2'b00, 0,  27, 3'd6, R, R, 1, 6'd1,  "ped_walk_k109");
    add(0, 2'b00, 0,   1, 3'd3, R, G, 0, 6'd30, "ped_egrn_k110");
    add(0, 2'b00, 0,  60, 3'd3, R, G, 0, 6'd18, "ped_egrn_k170");
    add(0, 2'b00, 0, 230, 3'd3, R, G, 0, 6'd0,  "ped_egrn_k400");

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) begin
        do_reset(vecs[i].sw, vecs[i].ped);
      end else begin
        bus.SW  = vecs[i].sw;
        bus.PED = vecs[i].ped;
      end
      if (vecs[i].n > 0) begin
        repeat (vecs[i].n) @(posedge clk);
        @(negedge clk);
      end
      check_outputs(vecs[i].name, vecs[i].phase, vecs[i].led_n, vecs[i].led_e,
                    vecs[i].walk, vecs[i].sec);
    end

    // Asynchronous reset in the middle of E_YELLOW, observed before the next edge.
    do_reset(2'b11, 1'b0);
    repeat (325) @(posedge clk);
    @(negedge clk);
    check_outputs("arst_pre", 3'd4, R, Y, 0, 6'd2);
    #3;
    key = 1'b0;
    #1;
    check_outputs("arst_async", 3'd0, G, R, 0, 6'd30);
    @(negedge clk);
    key = 1'b1;
    bus.SW = 2'b00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_outputs("arst_after", 3'd0, G, R, 0, 6'd28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Phase scheduler for the two-way (North/East) intersection with a pedestrian crossing. It arbitrates between the North car sensor, the East car sensor and a latched pedestrian request, and sequences green/yellow/all-red/walk phases against second-based timers. LED encoding matches the existing traffic_light block, so this block drops into the same top level alongside the seven-segment countdown logic.

Parameters:
CNT_MAX, 50000000, clocks per 1 s tick (the bench overrides this to 5)
T_MIN_GREEN, 10, minimum green seconds before yielding
T_MAX_GREEN, 30, maximum green seconds while the own side still has demand
T_YELLOW, 3, yellow seconds
T_ALLRED, 1, all-red clearance seconds
T_WALK, 8, pedestrian walk seconds

Ports:
CLOCK_50  in   1  system clock
KEY       in   1  reset, asynchronous, active-low
SW        in   2  car sensors: SW[0]=North, SW[1]=East; level, asynchronous, 2-flop synchronised
PED       in   1  pedestrian button; asynchronous, 2-flop synchronised, rising edge latched
LED_N     out  3  North lamps: 001 green, 010 yellow, 100 red
LED_E     out  3  East lamps, same encoding as LED_N
WALK      out  1  pedestrian walk lamp
SEC_LEFT  out  6  seconds remaining in the current phase
PHASE     out  3  current state encoding

Behaviour:
- States (PHASE): N_GREEN=0, N_YELLOW=1, ALLRED_N=2, E_GREEN=3, E_YELLOW=4, ALLRED_E=5, PED_WALK=6. Codes 7 are illegal and recover to N_GREEN on the next clock.
- Reset (KEY=0, takes effect immediately without a clock edge):
  - state N_GREEN; LED_N=001, LED_E=100; WALK=0.
  - SEC_LEFT=T_MAX_GREEN; PHASE=0.
  - ped_pending=0, next_dir=East, prescaler=0, elapsed=0, synchronisers cleared.
- Prescaler:
  - Counts 0..CNT_MAX-1 and asserts tick for one cycle at CNT_MAX-1.
  - Reloads to 0 on every state entry, so each timed phase lasts exactly T*CNT_MAX clocks.
- elapsed: 6-bit count of ticks since state entry, saturating at 63.
- All transitions are evaluated only on tick. The state changes on the clock edge that ends the tick cycle. Outputs are registered and update on that same edge.
- N_GREEN exits to N_YELLOW when the competing request (east_car OR ped_pending) is set AND either:
  - elapsed+1 >= T_MAX_GREEN, or
  - elapsed+1 >= T_MIN_GREEN and north_car=0.
  
  With no competing request, N_GREEN rests indefinitely. E_GREEN is symmetric, using north_car OR ped_pending and exiting to E_YELLOW.
- X_YELLOW goes to ALLRED_X after T_YELLOW ticks.
- ALLRED_N, after T_ALLRED ticks:
  - if ped_pending, go to PED_WALK with next_dir=East;
  - otherwise go to E_GREEN.
  
  ALLRED_E is symmetric, using next_dir=North and N_GREEN.
- PED_WALK goes to the next_dir green after T_WALK ticks.
- ped_pending:
  - Set on a synchronised PED rising edge in any state except PED_WALK; edges during PED_WALK are ignored.
  - Cleared on entry to PED_WALK.
  - Decisions use the registered value, so an edge arriving in the same cycle as a deciding tick is served at the next decision.
- Lamps per state:
  - GREEN: own side 001, other side 100.
  - YELLOW: own side 010, other side 100.
  - ALLRED and PED_WALK: both sides 100.
  - WALK=1 only in PED_WALK.
- SEC_LEFT:
  - Timed phases: duration − elapsed.
  - Greens: T_MAX_GREEN − elapsed, saturating at 0 (it holds 0 while resting).
  - Reloads to the full duration on entry.
- Total input-to-decision latency: 2 synchroniser cycles plus wait for the next tick.

Test Plan:
(CNT_MAX=5, 20 ns clock)
1. Release reset with SW=00, PED=0, then run 1000 clocks → LED_N=001, LED_E=100, PHASE=0 throughout, SEC_LEFT=0 after 150 clocks.
2. Set SW=10 at green entry → N_GREEN lasts 50 clocks, then LED_N=010 for 15 clocks, then both 100 for 5 clocks, then LED_E=001 with PHASE=3.
3. Set SW=11 → each green lasts exactly 150 clocks; phases cycle 0→1→2→3→4→5→0 with yellow=15 and all-red=5 clocks.
4. SW=00 and a PED pulse of 2 clocks during N_GREEN → yield after 50 clocks, then yellow, then all-red, then PHASE=6 with WALK=1 and both lamps 100 for 40 clocks, then E_GREEN. A second PED pulse during walk is not served afterwards.
5. Assert KEY=0 mid E_YELLOW between clock edges → LED_N=001, LED_E=100, WALK=0, PHASE=0, SEC_LEFT=30 before the next edge.
6. In N_YELLOW, check SEC_LEFT reads 3, 2, 1 at successive ticks and reloads on entry to ALLRED_N.
